// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: LSB-first data framed by a start bit (0) and a stop bit (1).
// Defining SERIAL_TX_PARITY_EN inserts an even-parity bit between the data and the stop bit.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [2:0]        fsm_state
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state, next_state;
  logic [CW-1:0]     cnt, next_cnt;
  logic [BW-1:0]     bit_cnt, next_bit;
  logic [DATA_W-1:0] shift, next_shift;
  logic              next_tx;
  logic              slot_end;

  // Handshake: a word moves on a rising edge where tx_valid and tx_ready are both high;
  // tx_ready is high only in IDLE, so tx_data/tx_valid are ignored for the whole frame.
  assign tx_ready  = (state == IDLE);
  assign fsm_state = 3'(state);
  assign slot_end  = (cnt == CNT_LAST);

  always_comb begin
    next_state = state;
    next_cnt   = cnt + CW'(1);
    next_bit   = bit_cnt;
    next_shift = shift;
    unique case (state)
      IDLE: begin
        next_cnt = '0;
        if (tx_valid) begin
          next_state = START;
          next_shift = tx_data;
          next_bit   = '0;
        end
      end
      START: begin
        if (slot_end) begin
          next_state = DATA;
          next_cnt   = '0;
        end
      end
      DATA: begin
        if (slot_end) begin
          next_cnt   = '0;
          next_shift = shift >> 1;
          if (bit_cnt == BIT_LAST) begin
            next_bit = '0;
`ifdef SERIAL_TX_PARITY_EN
            next_state = PARITY;
`else
            next_state = STOP;
`endif
          end else begin
            next_bit = bit_cnt + BW'(1);
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (slot_end) begin
          next_state = STOP;
          next_cnt   = '0;
        end
      end
`endif
      STOP: begin
        if (slot_end) begin
          next_state = IDLE;
          next_cnt   = '0;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

`ifdef SERIAL_TX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else if (tx_ready && tx_valid) begin
      parity_q <= ^tx_data;
    end
  end
`endif

  // tx is registered from the upcoming state so the line level lines up with the state.
  always_comb begin
    next_tx = 1'b1;
    case (next_state)
      START:   next_tx = 1'b0;
      DATA:    next_tx = next_shift[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  next_tx = parity_q;
`endif
      default: next_tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= next_state;
      cnt     <= next_cnt;
      bit_cnt <= next_bit;
      shift   <= next_shift;
      tx      <= next_tx;
      busy    <= (next_state != IDLE);
      done    <= (state == STOP) && (next_state == IDLE);
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: randomized words checked against a slot-based line model.
// Build with SERIAL_TX_PARITY_EN defined to also exercise the parity slot.
module tb_serial_tx;

  localparam int DATA_W       = 8;
  localparam int CLKS_PER_BIT = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int SLOTS = DATA_W + 3;
`else
  localparam int SLOTS = DATA_W + 2;
`endif
  localparam int FL = SLOTS * CLKS_PER_BIT;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx;
  logic              busy;
  logic              done;
  logic [2:0]        fsm_state;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [0:0] exp_q[$];

  always #5 clk = ~clk;

  serial_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CLKS_PER_BIT)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  // Line level at cycle idx of a frame, from the slot the cycle falls in.
  function automatic logic model_bit(input logic [DATA_W-1:0] word, input int idx);
    int slot;
    slot = idx / CLKS_PER_BIT;
    if (slot == 0) return 1'b0;
    if (slot <= DATA_W) return word[slot-1];
`ifdef SERIAL_TX_PARITY_EN
    if (slot == DATA_W + 1) return ^word;
`endif
    return 1'b1;
  endfunction

  // Called right after the handshake edge; ends at the sample of the done cycle.
  task automatic check_frame(input logic [DATA_W-1:0] word, input string tag);
    logic e;
    exp_q.delete();
    for (int i = 0; i < FL; i++) exp_q.push_back(model_bit(word, i));
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (tx !== e) begin
        n_err++;
        $display("FAIL %s tx cycle %0d: got %b expected %b", tag, i, tx, e);
      end
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0 || tx_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s flags cycle %0d: got busy=%b done=%b ready=%b expected 1 0 0",
                 tag, i, busy, done, tx_ready);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1 || tx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s done_cycle: got done=%b busy=%b tx=%b ready=%b expected 1 0 1 1",
               tag, done, busy, tx, tx_ready);
    end
  endtask

  task automatic drive_word(input logic [DATA_W-1:0] word);
    @(posedge clk); #1;
    tx_data  = word;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    tx_data  = DATA_W'($urandom);
  endtask

  task automatic check_idle(input string tag, input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1 || tx_ready !== 1'b1) begin
        n_err++;
        $display("FAIL %s idle: got done=%b busy=%b tx=%b ready=%b expected 0 0 1 1",
                 tag, done, busy, tx, tx_ready);
      end
    end
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] w;
    w        = DATA_W'($urandom);
    tx_data  = w;
    tx_valid = 1'b1;
    reset    = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || tx_ready !== 1'b1) begin
        n_err++;
        $display("FAIL reset_hold: got tx=%b busy=%b done=%b ready=%b expected 1 0 0 1",
                 tx, busy, done, tx_ready);
      end
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: got tx=%b busy=%b ready=%b expected 1 0 1", tx, busy, tx_ready);
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    check_frame(w, "reset_first_frame");
  endtask

  task automatic test_single_frame();
    logic [DATA_W-1:0] words[4];
    words[0] = DATA_W'(8'hA5);
    for (int k = 1; k < 4; k++) words[k] = DATA_W'($urandom);
    for (int k = 0; k < 4; k++) begin
      drive_word(words[k]);
      check_frame(words[k], "single");
      check_idle("single_after", 2);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] r;
    r = DATA_W'($urandom);
    @(posedge clk); #1;
    tx_data  = '0;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data = '1;
    check_frame('0, "b2b_zero");
    @(posedge clk); #1;
    tx_data = r;
    check_frame('1, "b2b_ones");
    @(posedge clk); #1;
    tx_valid = 1'b0;
    check_frame(r, "b2b_rand");
    check_idle("b2b_after", 2);
  endtask

  task automatic test_ignore_busy();
    drive_word(DATA_W'(8'h81));
    fork
      check_frame(DATA_W'(8'h81), "ignore_busy");
      begin
        repeat (10) @(posedge clk);
        #1;
        tx_data  = DATA_W'(8'h3C);
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
      end
    join
    check_idle("ignore_after", 4);
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] w, w2;
    logic e;
    w  = DATA_W'($urandom) & ~DATA_W'(8);
    w2 = DATA_W'($urandom);
    drive_word(w);
    for (int i = 0; i < 4 * CLKS_PER_BIT + 2; i++) begin
      @(negedge clk);
      e = model_bit(w, i);
      n_cmp++;
      if (tx !== e) begin
        n_err++;
        $display("FAIL reset_mid_pre tx cycle %0d: got %b expected %b", i, tx, e);
      end
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || tx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_async: got tx=%b busy=%b done=%b ready=%b expected 1 0 0 1",
               tx, busy, done, tx_ready);
    end
    check_idle("reset_mid_hold", 2);
    @(posedge clk); #1;
    reset = 1'b1;
    check_idle("reset_mid_release", 3);
    drive_word(w2);
    check_frame(w2, "reset_mid_next");
  endtask

`ifdef SERIAL_TX_PARITY_EN
  task automatic test_parity(input logic [DATA_W-1:0] w, input logic par);
    int n_busy;
    n_busy = 0;
    drive_word(w);
    for (int i = 0; i < FL + 1; i++) begin
      @(negedge clk);
      if (busy === 1'b1) n_busy++;
      if (i == (DATA_W + 1) * CLKS_PER_BIT + 1) begin
        n_cmp++;
        if (tx !== par) begin
          n_err++;
          $display("FAIL parity_slot word=%h: got %b expected %b", w, tx, par);
        end
      end
    end
    n_cmp++;
    if (n_busy !== 44) begin
      n_err++;
      $display("FAIL parity_frame_len word=%h: got %0d expected 44", w, n_busy);
    end
    check_idle("parity_after", 2);
  endtask
`endif

  initial begin
    reset    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
`ifdef SERIAL_TX_PARITY_EN
    test_parity(DATA_W'(8'hA5), 1'b0);
    test_parity(DATA_W'(8'h07), 1'b1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Parallel-to-serial bit-stream transmitter. It produces the single-bit serial input stream that the team's serial pattern detectors and receivers consume. Each parallel word is accepted over a valid/ready handshake and emitted LSB-first inside a start/stop frame, with every bit held for a fixed number of clock cycles. It sits between a word producer and the serial line.

Parameters:
DATA_W, 8, data bits per frame (1..16)
CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
tx_data  input  DATA_W  word to transmit; sampled only at handshake
tx_valid  input  1  producer has a word on tx_data
tx_ready  output  1  block can accept a word this cycle
tx  output  1  serial line; idles high
busy  output  1  frame in progress (any state other than IDLE)
done  output  1  one-cycle pulse: a frame just completed

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; tx=1, busy=0, done=0, tx_ready=1.
  - Shift register and bit/cycle counters clear.
  - Reset mid-frame aborts the frame immediately; the partial frame is never resumed.
- All outputs are registered except tx_ready, which is combinational: tx_ready = (state==IDLE).
- Handshake: a word is accepted at the rising edge where tx_valid & tx_ready are both 1.
  - tx_data is copied into the shift register on that edge.
  - tx_data and tx_valid are ignored while busy.
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see Optional Feature).
  - IDLE: tx=1. Go to START on handshake.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx = shift_reg[0] for CLKS_PER_BIT cycles. Then shift right by 1 and increment the bit counter. After DATA_W bits, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Per-state timing:
  - A cycle counter counts 0..CLKS_PER_BIT-1 within each state.
  - It is reset to 0 on every state transition.
  - CLKS_PER_BIT=1 gives one cycle per bit, with no extra cycles.
- Latency: tx falls to 0 in the cycle immediately after the handshake edge.
- Frame length: (2+DATA_W)*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
- done=1 for exactly the first IDLE cycle after STOP. It is 0 otherwise, including after a reset-aborted frame.
- busy=1 from the cycle after the handshake through the last STOP cycle.
- Back-to-back: with tx_valid held high, the next handshake occurs in the first IDLE cycle (same cycle as done).
  - Consecutive frames are separated by exactly one idle-high cycle.
- Counter widths are derived from $clog2 of CLKS_PER_BIT and DATA_W. No counter wraps within a legal frame.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = even-parity bit (XOR of the accepted word) for CLKS_PER_BIT cycles.
  - Parity is computed from the word captured at the handshake.
  - Frame length becomes (3+DATA_W)*CLKS_PER_BIT.
- Not defined: no PARITY state and no parity logic; DATA goes directly to STOP.

Test Plan:
- Reset: hold reset=0 for 3 cycles, tx_valid=1 -> tx=1, busy=0, done=0, tx_ready=1 throughout, with no handshake. Release -> handshake on the first edge.
- Single frame, CLKS_PER_BIT=4, tx_data=0xA5, one-cycle tx_valid -> tx per 4-cycle bit slot: 0, 1,0,1,0,0,1,0,1, 1. busy=1 for 40 cycles. done pulses once, on cycle 41.
- Back-to-back, tx_valid held with 0x00 then 0xFF -> exactly one tx=1 idle cycle between frames. Second data bits are all 1. done and tx_ready are coincident.
- Ignore while busy: change tx_data to 0x3C and pulse tx_valid mid-frame of 0x81 -> serial bits still match 0x81, and no second frame starts.
- Reset mid-frame: drop reset during the DATA bit 3 slot -> tx=1 asynchronously (same cycle), busy=0, and done never pulses. The next word transmits correctly.
- Parity (SERIAL_TX_PARITY_EN): 0xA5 -> parity slot tx=0. 0x07 -> parity slot tx=1. Frame length 44 cycles.
